// File: rtl/raster_frame_sequencer_pkg.sv
// rtl/raster_frame_sequencer_pkg.sv - shared types and constants for the raster frame sequencer
// Contents: raster_state_e (sequencer states), rgb565_t (framebuffer pixel),
//           COLOR_RED / COLOR_BLACK default colours.
package raster_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_LATCH  = 3'd3,
    ST_RASTER = 3'd4,
    ST_DONE   = 3'd5
  } raster_state_e;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t COLOR_RED   = 16'hF800;
  localparam rgb565_t COLOR_BLACK = 16'h0000;

endpackage

// File: rtl/raster_frame_sequencer_if.sv
// rtl/raster_frame_sequencer_if.sv - VRAM / point-tester / framebuffer bundle of the sequencer
// Signals: vram_rd_addr, vram_rd_data (sync VRAM read port); tri_data, pix_x, pix_y, hit
//          (tri_point_tester); fb_wr_en, fb_wr_addr, fb_wr_data (framebuffer write port).
// Modports: master = sequencer side, slave = memories / tester side.
interface raster_frame_sequencer_if #(
  parameter int DISPLAY_WIDTH         = 100,
  parameter int DISPLAY_HEIGHT        = 100,
  parameter int VRAM_DATA_BITS        = 8,
  parameter int VRAM_SIZE             = 256,
  parameter int FRAMEBUFFER_DATA_BITS = 16
);
  localparam int VRAM_ADDR_BITS        = $clog2(VRAM_SIZE);
  localparam int X_BITS                = $clog2(DISPLAY_WIDTH);
  localparam int Y_BITS                = $clog2(DISPLAY_HEIGHT);
  localparam int FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT);

  logic [VRAM_ADDR_BITS-1:0]        vram_rd_addr;
  logic [VRAM_DATA_BITS-1:0]        vram_rd_data;
  logic [VRAM_DATA_BITS-1:0]        tri_data;
  logic [X_BITS-1:0]                pix_x;
  logic [Y_BITS-1:0]                pix_y;
  logic                             hit;
  logic                             fb_wr_en;
  logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_wr_addr;
  logic [FRAMEBUFFER_DATA_BITS-1:0] fb_wr_data;

  modport master (
    output vram_rd_addr, input vram_rd_data,
    output tri_data, pix_x, pix_y, input hit,
    output fb_wr_en, fb_wr_addr, fb_wr_data
  );

  modport slave (
    input vram_rd_addr, output vram_rd_data,
    input tri_data, pix_x, pix_y, output hit,
    input fb_wr_en, fb_wr_addr, fb_wr_data
  );
endinterface

// File: rtl/raster_frame_sequencer_sweep.sv
// rtl/raster_frame_sequencer_sweep.sv - raster_pixel_sweep: x/y/linear pixel counters
// Ports: clk, rst_n (async active-low), clr (zero all counters), en (advance one pixel, x fastest),
//        x, y (coordinates), lin (row-major linear address), last (at x=W-1, y=H-1).
module raster_pixel_sweep #(
  parameter int DISPLAY_WIDTH  = 100,
  parameter int DISPLAY_HEIGHT = 100
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              clr,
  input  logic                                              en,
  output logic [$clog2(DISPLAY_WIDTH)-1:0]                  x,
  output logic [$clog2(DISPLAY_HEIGHT)-1:0]                 y,
  output logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0]   lin,
  output logic                                              last
);
  localparam int X_BITS = $clog2(DISPLAY_WIDTH);
  localparam int Y_BITS = $clog2(DISPLAY_HEIGHT);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(DISPLAY_HEIGHT - 1);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // The linear address runs alongside x/y so no y*W multiply is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      lin <= '0;
    end else if (clr || (en && last)) begin
      x   <= '0;
      y   <= '0;
      lin <= '0;
    end else if (en) begin
      lin <= lin + 1'b1;
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end
endmodule

// File: rtl/raster_frame_sequencer.sv
// rtl/raster_frame_sequencer.sv - frame controller: optional clear, per-triangle fetch and pixel sweep
// Ports: clk, rst (async active-low), start, tri_count (latched on accepted start, capped at VRAM_SIZE),
//        busy, frame_done (one-cycle pulse), bus (raster_frame_sequencer_if.master).
// Build option: RASTER_FRAME_CLEAR_EN enables the framebuffer CLEAR pass before the triangles.
module raster_frame_sequencer
  import raster_frame_sequencer_pkg::*;
#(
  parameter int      DISPLAY_WIDTH         = 100,
  parameter int      DISPLAY_HEIGHT        = 100,
  parameter int      VRAM_DATA_BITS        = 8,
  parameter int      VRAM_SIZE             = 256,
  parameter int      VRAM_ADDR_BITS        = $clog2(VRAM_SIZE),
  parameter int      FRAMEBUFFER_DATA_BITS = 16,
  parameter int      FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
  parameter rgb565_t TRI_COLOR             = COLOR_RED,
  parameter rgb565_t CLEAR_COLOR           = COLOR_BLACK
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [VRAM_ADDR_BITS:0]     tri_count,
  output logic                        busy,
  output logic                        frame_done,
  raster_frame_sequencer_if.master    bus
);
  localparam int CNT_BITS = VRAM_ADDR_BITS + 1;
  localparam logic [CNT_BITS-1:0] MAX_COUNT = CNT_BITS'(VRAM_SIZE);

  raster_state_e state, state_next;

  logic [CNT_BITS-1:0]                count;
  logic [CNT_BITS-1:0]                count_capped;
  logic [VRAM_ADDR_BITS-1:0]          tri_idx;
  logic [VRAM_DATA_BITS-1:0]          tri_data_q;
  logic                               last_tri;
  logic                               sweep_en;
  logic                               sweep_last;
  logic [$clog2(DISPLAY_WIDTH)-1:0]   sweep_x;
  logic [$clog2(DISPLAY_HEIGHT)-1:0]  sweep_y;
  logic [FRAMEBUFFER_ADDR_BITS-1:0]   sweep_lin;

  assign count_capped = (tri_count > MAX_COUNT) ? MAX_COUNT : tri_count;
  assign last_tri     = ({1'b0, tri_idx} == (count - 1'b1));

  raster_pixel_sweep #(
    .DISPLAY_WIDTH  (DISPLAY_WIDTH),
    .DISPLAY_HEIGHT (DISPLAY_HEIGHT)
  ) u_sweep (
    .clk   (clk),
    .rst_n (rst),
    .clr   (!sweep_en),
    .en    (sweep_en),
    .x     (sweep_x),
    .y     (sweep_y),
    .lin   (sweep_lin),
    .last  (sweep_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Frame bookkeeping: triangle count/index and the latched triangle word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      tri_idx    <= '0;
      tri_data_q <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        count   <= count_capped;
        tri_idx <= '0;
      end
      if (state == ST_LATCH) tri_data_q <= bus.vram_rd_data;
      if (state == ST_RASTER && sweep_last && !last_tri) tri_idx <= tri_idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef RASTER_FRAME_CLEAR_EN
          state_next = ST_CLEAR;
`else
          state_next = (count_capped != '0) ? ST_FETCH : ST_DONE;
`endif
        end
      end
      ST_CLEAR: begin
`ifdef RASTER_FRAME_CLEAR_EN
        if (sweep_last) state_next = (count != '0) ? ST_FETCH : ST_DONE;
`else
        state_next = ST_IDLE;
`endif
      end
      ST_FETCH:  state_next = ST_LATCH;
      ST_LATCH:  state_next = ST_RASTER;
      ST_RASTER: if (sweep_last) state_next = last_tri ? ST_DONE : ST_FETCH;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != ST_IDLE);
    frame_done     = (state == ST_DONE);
    sweep_en       = (state == ST_CLEAR) || (state == ST_RASTER);
    bus.fb_wr_en   = 1'b0;
    bus.fb_wr_data = '0;
    case (state)
      ST_CLEAR: begin
        bus.fb_wr_en   = 1'b1;
        bus.fb_wr_data = FRAMEBUFFER_DATA_BITS'(CLEAR_COLOR);
      end
      ST_RASTER: begin
        bus.fb_wr_en   = bus.hit;
        bus.fb_wr_data = FRAMEBUFFER_DATA_BITS'(TRI_COLOR);
      end
      default: ;
    endcase
  end

  assign bus.vram_rd_addr = tri_idx;
  assign bus.tri_data     = tri_data_q;
  assign bus.pix_x        = sweep_x;
  assign bus.pix_y        = sweep_y;
  assign bus.fb_wr_addr   = sweep_lin;
endmodule

// File: tb/tb_raster_frame_sequencer.sv
// tb/tb_raster_frame_sequencer.sv - scoreboard bench for raster_frame_sequencer (W=4, H=3, VRAM_SIZE=4)
module tb_raster_frame_sequencer;
  localparam int W     = 4;
  localparam int H     = 3;
  localparam int NPIX  = W * H;
  localparam int TCYC  = NPIX + 2;
  localparam int LIMIT = 200;
`ifdef RASTER_FRAME_CLEAR_EN
  localparam int P = NPIX;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] tri_count = '0;
  logic       busy;
  logic       frame_done;
  logic [7:0] vram [4];
  logic       hit_all = 1'b0;
  logic       hit_one = 1'b0;
  logic [1:0] hx = '0;
  logic [1:0] hy = '0;
  bit         sb_on = 1'b1;

  wr_t        exp_q[$];
  logic [1:0] fetch_q[$];
  logic [7:0] tri_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_pulses = 0;
  int writes_seen = 0;
  int busy_cycles = 0;

  raster_frame_sequencer_if #(
    .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .VRAM_DATA_BITS(8),
    .VRAM_SIZE(4), .FRAMEBUFFER_DATA_BITS(16)
  ) bus ();

  raster_frame_sequencer #(
    .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .VRAM_DATA_BITS(8), .VRAM_SIZE(4),
    .FRAMEBUFFER_DATA_BITS(16), .TRI_COLOR(16'hF800), .CLEAR_COLOR(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tri_count(tri_count),
    .busy(busy), .frame_done(frame_done), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.vram_rd_data <= vram[bus.vram_rd_addr];
  assign bus.hit = hit_all || (hit_one && bus.pix_x == hx && bus.pix_y == hy);

  always @(negedge clk) begin
    wr_t e;
    if (frame_done) done_pulses++;
    if (busy) busy_cycles++;
    if (bus.fb_wr_en) begin
      writes_seen++;
      if (sb_on) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL fb_write_unexpected: got addr %0d data %h, none expected", bus.fb_wr_addr, bus.fb_wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.fb_wr_addr, bus.fb_wr_data} !== {e.addr, e.data}) begin
            miscompares++;
            $display("FAIL fb_write: got addr %0d data %h, expected addr %0d data %h",
                     bus.fb_wr_addr, bus.fb_wr_data, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_clear();
`ifdef RASTER_FRAME_CLEAR_EN
    for (int i = 0; i < NPIX; i++) exp_q.push_back('{addr: 4'(i), data: 16'h0000});
`endif
  endtask

  task automatic push_hit(input int x, input int y);
    exp_q.push_back('{addr: 4'(y * W + x), data: 16'hF800});
  endtask

  // Runs one frame, recording the VRAM address in each FETCH cycle and tri_data in each first RASTER cycle.
  task automatic run_frame(input logic [2:0] n, input int poke, output int cyc);
    fetch_q.delete();
    tri_q.delete();
    start = 1'b1;
    tri_count = n;
    tick();
    start = 1'b0;
    cyc = -1;
    for (int c = 1; c <= LIMIT; c++) begin
      if (c == poke) begin
        start = 1'b1;
        tri_count = 3'd7;
      end else begin
        start = 1'b0;
      end
      if (frame_done) begin
        cyc = c;
        break;
      end
      if (busy && c > P && (c - P - 1) % TCYC == 0) fetch_q.push_back(bus.vram_rd_addr);
      if (busy && c > P + 2 && (c - P - 3) % TCYC == 0) tri_q.push_back(bus.tri_data);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if ({busy, frame_done, bus.fb_wr_en, bus.fb_wr_addr, bus.fb_wr_data, bus.pix_x, bus.pix_y,
         bus.tri_data, bus.vram_rd_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b wr_en=%b addr=%0d data=%h x=%0d y=%0d tri=%h vaddr=%0d, expected all 0",
               busy, frame_done, bus.fb_wr_en, bus.fb_wr_addr, bus.fb_wr_data, bus.pix_x, bus.pix_y,
               bus.tri_data, bus.vram_rd_addr);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_empty_frame();
    int cyc, b0;
    hit_all = 1'b0; hit_one = 1'b0;
    push_clear();
    b0 = busy_cycles;
    run_frame(3'd0, -1, cyc);
    vectors++;
    if (cyc !== P + 1) begin
      miscompares++;
      $display("FAIL empty_frame_done_cycle: got %0d, expected %0d", cyc, P + 1);
    end
    vectors++;
    if (busy_cycles - b0 !== P + 1) begin
      miscompares++;
      $display("FAIL empty_frame_busy_cycles: got %0d, expected %0d", busy_cycles - b0, P + 1);
    end
    tick();
    vectors++;
    if ({busy, frame_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_done: got busy=%b done=%b, expected 0 0", busy, frame_done);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL empty_frame_writes_missing: %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_single_hit();
    int cyc;
    vram[0] = 8'h5A;
    hit_one = 1'b1; hx = 2'd2; hy = 2'd1;
    push_clear();
    push_hit(2, 1);
    run_frame(3'd1, -1, cyc);
    tick();
    vectors++;
    if (cyc !== P + TCYC + 1) begin
      miscompares++;
      $display("FAIL single_hit_done_cycle: got %0d, expected %0d", cyc, P + TCYC + 1);
    end
    vectors++;
    if (fetch_q.size() !== 1 || fetch_q[0] !== 2'd0 || tri_q.size() !== 1 || tri_q[0] !== 8'h5A) begin
      miscompares++;
      $display("FAIL single_hit_fetch: got %0d fetches, %0d tri words (first addr/tri %0d/%h), expected 1, 1, 0/5a",
               fetch_q.size(), tri_q.size(), (fetch_q.size() > 0) ? fetch_q[0] : 2'd3,
               (tri_q.size() > 0) ? tri_q[0] : 8'hxx);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL single_hit_writes_missing: %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_full_sweep();
    int cyc;
    vram[0] = 8'h77;
    hit_one = 1'b0; hit_all = 1'b1;
    push_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) push_hit(x, y);
    run_frame(3'd1, -1, cyc);
    hit_all = 1'b0;
    tick();
    vectors++;
    if (cyc !== P + TCYC + 1) begin
      miscompares++;
      $display("FAIL full_sweep_done_cycle: got %0d, expected %0d", cyc, P + TCYC + 1);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL full_sweep_writes_missing: %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_three_triangles();
    int cyc;
    logic [7:0] words [3];
    words = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) vram[i] = words[i];
    hit_one = 1'b1; hx = 2'd1; hy = 2'd2;
    push_clear();
    for (int i = 0; i < 3; i++) push_hit(1, 2);
    run_frame(3'd3, -1, cyc);
    tick();
    vectors++;
    if (cyc !== P + 3 * TCYC + 1) begin
      miscompares++;
      $display("FAIL three_tri_done_cycle: got %0d, expected %0d", cyc, P + 3 * TCYC + 1);
    end
    vectors++;
    if (tri_q.size() !== 3 || fetch_q.size() !== 3) begin
      miscompares++;
      $display("FAIL three_tri_count: got %0d tri words %0d fetches, expected 3 3", tri_q.size(), fetch_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (tri_q[i] !== words[i] || fetch_q[i] !== 2'(i)) begin
          miscompares++;
          $display("FAIL three_tri_word%0d: got addr %0d tri %h, expected addr %0d tri %h",
                   i, fetch_q[i], tri_q[i], i, words[i]);
        end
      end
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL three_tri_writes_missing: %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_start_ignored();
    int cyc, d0;
    vram[0] = 8'h41; vram[1] = 8'h42;
    hit_one = 1'b1; hx = 2'd3; hy = 2'd2;
    push_clear();
    push_hit(3, 2);
    push_hit(3, 2);
    d0 = done_pulses;
    run_frame(3'd2, P + 6, cyc);
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (cyc !== P + 2 * TCYC + 1) begin
      miscompares++;
      $display("FAIL start_ignored_done_cycle: got %0d, expected %0d", cyc, P + 2 * TCYC + 1);
    end
    vectors++;
    if (done_pulses - d0 !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ignored_pulses: got %0d pulses busy=%b, expected 1 pulse busy=0", done_pulses - d0, busy);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL start_ignored_writes_missing: %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc, d0, w0;
    for (int i = 0; i < 4; i++) vram[i] = 8'(8'hC0 + i);
    hit_one = 1'b0; hit_all = 1'b1;
    sb_on = 1'b0;
    d0 = done_pulses;
    start = 1'b1;
    tri_count = 3'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c < P + TCYC + 6; c++) tick();
    vectors++;
    if (bus.fb_wr_en !== 1'b1 || bus.tri_data !== 8'hC1) begin
      miscompares++;
      $display("FAIL pre_reset_raster: got wr_en=%b tri=%h, expected 1 c1", bus.fb_wr_en, bus.tri_data);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({busy, frame_done, bus.fb_wr_en, bus.fb_wr_addr, bus.fb_wr_data, bus.pix_x, bus.pix_y,
         bus.tri_data, bus.vram_rd_addr} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: busy=%b wr_en=%b addr=%0d x=%0d y=%0d tri=%h vaddr=%0d, expected all 0",
               busy, bus.fb_wr_en, bus.fb_wr_addr, bus.pix_x, bus.pix_y, bus.tri_data, bus.vram_rd_addr);
    end
    tick();
    rst = 1'b1;
    w0 = writes_seen;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (done_pulses - d0 !== 0 || writes_seen - w0 !== 0) begin
      miscompares++;
      $display("FAIL reset_abort: got %0d pulses %0d writes, expected 0 0", done_pulses - d0, writes_seen - w0);
    end
    hit_all = 1'b0;
    sb_on = 1'b1;
    hit_one = 1'b1; hx = 2'd0; hy = 2'd0;
    push_clear();
    push_hit(0, 0);
    run_frame(3'd1, -1, cyc);
    tick();
    vectors++;
    if (cyc !== P + TCYC + 1 || fetch_q.size() !== 1 || fetch_q[0] !== 2'd0 || tri_q[0] !== 8'hC0) begin
      miscompares++;
      $display("FAIL restart_after_reset: got cycle %0d fetches %0d tri %h, expected %0d 1 c0",
               cyc, fetch_q.size(), (tri_q.size() > 0) ? tri_q[0] : 8'hxx, P + TCYC + 1);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL restart_writes_missing: %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_count_saturation();
    int cyc;
    logic [7:0] words [4];
    words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) vram[i] = words[i];
    hit_one = 1'b1; hx = 2'd0; hy = 2'd0;
    push_clear();
    for (int i = 0; i < 4; i++) push_hit(0, 0);
    run_frame(3'd7, -1, cyc);
    tick();
    vectors++;
    if (cyc !== P + 4 * TCYC + 1) begin
      miscompares++;
      $display("FAIL saturate_done_cycle: got %0d, expected %0d", cyc, P + 4 * TCYC + 1);
    end
    vectors++;
    if (fetch_q.size() !== 4 || tri_q.size() !== 4) begin
      miscompares++;
      $display("FAIL saturate_fetch_count: got %0d fetches %0d tri words, expected 4 4", fetch_q.size(), tri_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (fetch_q[i] !== 2'(i) || tri_q[i] !== words[i]) begin
          miscompares++;
          $display("FAIL saturate_tri%0d: got addr %0d tri %h, expected addr %0d tri %h",
                   i, fetch_q[i], tri_q[i], i, words[i]);
        end
      end
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL saturate_writes_missing: %0d left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) vram[i] = '0;
    test_reset();
    test_empty_frame();
    test_single_hit();
    test_full_sweep();
    test_three_triangles();
    test_start_ignored();
    test_reset_mid_frame();
    test_count_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
